test_st_source: RTL and testbench
=================================

Name: test_st_source

Overview:
- Streaming test-pattern transmitter: the producer end of the valid/ready streaming interface that `test_st_sink` consumes.
- On a start pulse it emits a burst of `burst_len` beats of deterministic data (incrementing or LFSR), honouring `ready` backpressure.
- Used to exercise streaming datapaths and sinks on the DE10-Nano fabric.
- Reports progress through busy, done and a count of accepted beats.

Parameters:
- DATA_WIDTH, 256: stream data width in bits; must be a multiple of 32.
- LEN_WIDTH, 16: width of the burst length and beat counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle burst request; honoured only in IDLE.
- burst_len  input  LEN_WIDTH  number of beats; sampled when start is accepted.
- mode  input  1  0 = incrementing pattern, 1 = LFSR pattern; sampled with start.
- st_data  output  DATA_WIDTH  beat payload.
- valid  output  1  payload valid.
- last  output  1  marks the final beat of the burst.
- ready  input  1  sink can accept the beat.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last beat is accepted.
- beat_count  output  LEN_WIDTH  beats accepted in the current or most recent burst.

Behaviour:
- Reset: all outputs 0 (st_data, valid, last, busy, done, beat_count); FSM to IDLE; LFSR loaded with seed 0xACE10001.
- Transfer: a transfer occurs on a cycle where valid && ready.
- valid never depends on the current value of ready.
- While valid && !ready, st_data and last hold stable.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start = 1 and burst_len != 0.
  - Same edge: latch burst_len and mode, clear beat_count, reseed the LFSR, set busy = 1.
  - valid = 1 with beat 0 from the next cycle (1-cycle latency from start).
- start with burst_len = 0: ignored. Stay in IDLE, no valid, no done.
- RUN: each transfer increments beat_count and the sequence index, then presents the next beat on the following cycle.
  - Back-to-back transfers sustain 1 beat/cycle.
  - last = 1 exactly when the presented beat index equals burst_len − 1.
- RUN → DONE on the transfer of the last beat.
  - Next cycle: valid = 0, last = 0, busy = 0, done = 1.
- DONE → IDLE unconditionally after one cycle; done returns to 0.
  - beat_count holds its final value until the next accepted start.
- start asserted in RUN or DONE: ignored, not queued.
- Incrementing pattern: with N = DATA_WIDTH/32 lanes, lane k (bits 32k+31:32k) = (seq·N + k) mod 2^32.
  - seq is the beat index, starting at 0.
- LFSR pattern:
  - 32-bit Galois LFSR, right-shifting, mask 0x80200003 (x^32+x^22+x^2+x+1).
  - Next state = (s>>1) XOR (s[0] ? 0x80200003 : 0).
  - Advances once per transfer.
  - Lane k = current LFSR state rotated left by k bits.
  - Beat 0 = seed.
- Synchronous rst mid-burst: on the next edge valid, last, busy, done and beat_count go to 0 and FSM goes to IDLE.
  - No partial-burst done pulse is produced.
  - A later start begins from beat 0 and the seed.
- start and rst in the same cycle: rst wins.

Decomposition:
- Package test_st_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LANE_W = 32;
  - LFSR_SEED = 32'hACE10001;
  - LFSR_POLY = 32'h80200003;
  - the mode encoding constants.
- One sub-module, st_lfsr32.
  - Inputs: clk, rst, load, advance.
  - Output: 32-bit state.
  - load has priority over advance.
- Lane expansion and the incrementing pattern stay in test_st_source.

Test Plan:
- DATA_WIDTH=256, ready held 1, start with burst_len=4, mode=0 → valid on 4 consecutive cycles starting 1 cycle after start; lane0 = 0, 8, 16, 24 and lane7 = 7, 15, 23, 31; last only on beat 3; done pulses once on the following cycle; beat_count = 4.
- burst_len=3, mode=0, ready pattern 1,0,0,1,0,1 → exactly 3 transfers; st_data and last unchanged across the stall cycles; no duplicated or skipped beats; done after the third transfer.
- burst_len=2, mode=1, ready=1 → beat0 lane0 = 0xACE10001 and lane1 = 0x59C20003; beat1 lane0 = 0xD6508003; last on beat1.
- burst_len=1 → single beat with valid=last=1, then done; burst_len=0 → no valid, no done, busy stays 0.
- start re-pulsed during RUN → ignored, burst length unchanged. Then rst asserted after 2 of 5 beats → next cycle valid=0, busy=0, beat_count=0, no done pulse; a fresh start replays beat 0 (lane0 = 0).
- Protocol checker over all tests:
  - no change of st_data or last while valid && !ready;
  - valid never deasserts without a transfer except on rst.

Source files
------------

// File: rtl/test_st_pkg.sv
// test_st_pkg: shared state, mode and LFSR definitions for the streaming test source
package test_st_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {MODE_INC, MODE_LFSR} mode_t;
  localparam int LANE_W = 32;
  localparam logic [31:0] LFSR_SEED = 32'hACE10001;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} << (n % 32);
    return d[63:32];
  endfunction
endpackage

// File: rtl/st_lfsr32.sv
// st_lfsr32: 32-bit right-shifting Galois LFSR, reseeded by rst or load, stepped by advance
// clk/rst: clock and sync active-high reset; load: reseed (wins over advance); advance: step once; state: current value
module st_lfsr32
  import test_st_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);
  always_ff @(posedge clk)
    if (rst || load) state <= LFSR_SEED;
    else if (advance) state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
endmodule

// File: rtl/test_st_source.sv
// test_st_source: valid/ready burst transmitter of incrementing or LFSR test data
// clk/rst: clock and sync active-high reset; start/burst_len/mode: burst request, taken only in IDLE
// st_data/valid/last/ready: outgoing stream beat; busy/done/beat_count: burst progress
module test_st_source
  import test_st_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  valid,
  output logic                  last,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_count
);
  localparam int N = DATA_WIDTH / LANE_W;
  state_t state, state_n;
  mode_t mode_q;
  logic [LEN_WIDTH-1:0] len_q, seq;
  logic [31:0] lfsr;
  logic [DATA_WIDTH-1:0] pattern;
  logic go, xfer;
  assign go = state == IDLE && start && burst_len != '0;
  assign valid = state == RUN;
  assign xfer = valid && ready;
  assign busy = valid;
  assign done = state == DONE;
  assign last = valid && seq == len_q - LEN_WIDTH'(1);
  // payload is a pure function of held registers, so it stays stable while stalled
  assign st_data = valid ? pattern : '0;
  always_comb begin
    pattern = '0;
    for (int k = 0; k < N; k++)
      pattern[k*LANE_W +: LANE_W] = mode_q == MODE_LFSR ? rotl32(lfsr, k)
                                                        : 32'(seq) * 32'(N) + 32'(k);
  end
  always_comb state_n = state == IDLE ? (go ? RUN : IDLE) :
                        state == RUN  ? (xfer && last ? DONE : RUN) : IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      len_q      <= '0;
      seq        <= '0;
      mode_q     <= MODE_INC;
      beat_count <= '0;
    end else if (go) begin
      len_q      <= burst_len;
      seq        <= '0;
      mode_q     <= mode_t'(mode);
      beat_count <= '0;
    end else if (xfer) begin
      seq        <= seq + LEN_WIDTH'(1);
      beat_count <= beat_count + LEN_WIDTH'(1);
    end
  st_lfsr32 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (go),
    .advance(xfer),
    .state  (lfsr)
  );
endmodule

// File: tb/tb_test_st_source.sv
// tb_test_st_source: randomized scoreboard bench for the streaming test source
module tb_test_st_source;
  localparam int DW = 256;
  localparam int LW = 16;
  localparam int N  = DW / 32;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [LW-1:0] idx;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, mode = 0, ready = 0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] st_data;
  logic valid, last, busy, done;
  logic [LW-1:0] beat_count;
  exp_t q[$];
  exp_t it;
  int chk = 0, fail = 0, to_cnt = 0;
  bit fin = 0;
  logic rst_d = 1, pv = 0, pr = 0, plast = 0, exp_done = 0;
  logic [DW-1:0] pdata = '0;
  logic [LW-1:0] exp_bc = '0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  test_st_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .mode(mode),
    .st_data(st_data), .valid(valid), .last(last), .ready(ready),
    .busy(busy), .done(done), .beat_count(beat_count)
  );

  // reference: beat j, lane k is j*N+k, or the j-th LFSR value rotated left by k
  task automatic push_burst(input int len, input bit md);
    logic [31:0] s, v;
    exp_t e;
    s = 32'hACE10001;
    for (int j = 0; j < len; j++) begin
      for (int k = 0; k < N; k++) begin
        v = md ? ((k == 0) ? s : (s << k) | (s >> (32 - k))) : 32'(j * N + k);
        e.data[k*32 +: 32] = v;
      end
      e.last = (j == len - 1);
      e.idx  = LW'(j);
      q.push_back(e);
      s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    end
  endtask

  // rp: 0 ready held high, 1 fixed stall pattern, 2 random; repulse re-requests in RUN and DONE
  task automatic burst(input int len, input bit md, input int rp, input bit repulse);
    bit got;
    @(posedge clk); #1;
    start = 1; burst_len = LW'(len); mode = md;
    push_burst(len, md);
    @(posedge clk); #1;
    start = 0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      ready = rp == 0 ? 1'b1 : rp == 1 ? pat[i % 6] : 1'($urandom_range(0, 3) != 0);
      start = repulse && i == 1;
      if (start) burst_len = LW'(len + 3);
      @(posedge clk); #1;
      got = done;
    end
    if (!got) to_cnt++;
    start = repulse;
    ready = 0;
    @(posedge clk); #1;
    start = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    burst(4, 0, 0, 0);
    burst(3, 0, 1, 0);
    burst(2, 1, 0, 0);
    burst(1, 0, 0, 0);
    @(posedge clk); #1;
    start = 1; burst_len = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    burst(5, 1, 2, 1);
    @(posedge clk); #1;
    start = 1; burst_len = 5; mode = 0; ready = 1;
    push_burst(5, 0);
    @(posedge clk); #1;
    start = 1; burst_len = 9;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    rst = 1; ready = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    burst(5, 0, 2, 0);
    @(posedge clk); #1;
    rst = 1; start = 1; burst_len = 4;
    @(posedge clk); #1;
    rst = 0; start = 0;
    repeat (4) @(posedge clk);
    for (int r = 0; r < 8; r++)
      burst(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
    repeat (3) @(posedge clk);
    #1 fin = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (fin) begin
      chk++;
      if (q.size() != 0) begin
        fail++;
        $display("FAIL leftover_beats: %0d expected beats never sent, required 0", q.size());
      end
      chk++;
      if (to_cnt != 0) begin
        fail++;
        $display("FAIL done_timeout: %0d bursts never signalled done, required 0", to_cnt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
      $finish;
    end else begin
      if (rst_d) begin
        chk++;
        if ({valid, last, busy, done} !== 4'b0 || beat_count !== '0 || st_data !== '0) begin
          fail++;
          $display("FAIL reset_outputs: valid=%b last=%b busy=%b done=%b beat_count=%0d data=%h, required all 0",
                   valid, last, busy, done, beat_count, st_data);
        end
      end else begin
        chk++;
        if (done !== exp_done) begin
          fail++;
          $display("FAIL done_pulse: got %b required %b", done, exp_done);
        end
        chk++;
        if (busy !== valid) begin
          fail++;
          $display("FAIL busy: got %b required %b", busy, valid);
        end
        if (exp_done) begin
          chk++;
          if (valid !== 1'b0 || last !== 1'b0) begin
            fail++;
            $display("FAIL done_cycle: valid=%b last=%b, required 0 0", valid, last);
          end
        end
        if (valid !== 1'b1) begin
          chk++;
          if (beat_count !== exp_bc) begin
            fail++;
            $display("FAIL beat_count_idle: got %0d required %0d", beat_count, exp_bc);
          end
        end else if (q.size() == 0) begin
          chk++;
          fail++;
          $display("FAIL unexpected_beat: valid=1 data=%h, required no beat", st_data);
        end else begin
          it = q[0];
          chk++;
          if (st_data !== it.data) begin
            fail++;
            $display("FAIL data idx=%0d: got %h required %h", it.idx, st_data, it.data);
          end
          chk++;
          if (last !== it.last) begin
            fail++;
            $display("FAIL last idx=%0d: got %b required %b", it.idx, last, it.last);
          end
          chk++;
          if (beat_count !== it.idx) begin
            fail++;
            $display("FAIL beat_count_run: got %0d required %0d", beat_count, it.idx);
          end
        end
        if (pv && !pr) begin
          chk++;
          if (valid !== 1'b1 || st_data !== pdata || last !== plast) begin
            fail++;
            $display("FAIL stall_hold: valid=%b last=%b data=%h, required 1 %b %h",
                     valid, last, st_data, plast, pdata);
          end
        end
      end
      exp_done = 0;
      if (valid === 1'b1 && ready && !rst && !rst_d && q.size() != 0) begin
        it = q.pop_front();
        exp_bc = it.idx + LW'(1);
        exp_done = it.last;
      end
      if (rst) begin
        q.delete();
        exp_bc = '0;
      end
      pv = valid === 1'b1 && !rst;
      pr = ready;
      pdata = st_data;
      plast = last;
      rst_d = rst;
    end
  end
endmodule
